// File: rtl/data_sram_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : data_sram_responder_pkg
// Description : Shared access-size encodings, limits and lane-merge helper.
// Revision    : 1.0 - initial release
// ============================================================================
package data_sram_responder_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } size_e;

    localparam int OUTSTANDING_MAX = 4;
    localparam int RESP_DELAY_MAX  = 7;
    localparam int DELAY_W         = 3;

    function automatic logic [31:0] merge_lanes(
        input logic [31:0] old_word,
        input logic [31:0] new_word,
        input logic [3:0]  strb
    );
        logic [31:0] merged;
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage
`default_nettype wire

// File: rtl/data_sram_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : data_sram_responder_if
// Description : Data-SRAM request/response bus between EX stage and responder.
// Revision    : 1.0 - initial release
// ============================================================================
interface data_sram_responder_if;
    import data_sram_responder_pkg::*;

    logic        req;
    logic        wr;
    size_e       size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output req, wr, size, wstrb, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, wstrb, addr, wdata,
        output addr_ok, data_ok, rdata
    );

endinterface
`default_nettype wire

// File: rtl/data_sram_responder_resp_fifo.sv
`default_nettype none
// ============================================================================
// Module      : resp_fifo
// Description : In-order response FIFO; each entry carries its own countdown.
// Revision    : 1.0 - initial release
// ============================================================================
module resp_fifo #(
    parameter int DEPTH      = 2,
    parameter int WIDTH      = 33,
    parameter int DELAY_W    = 3,
    parameter int DELAY_INIT = 1,
    parameter int CNT_W      = $clog2(DEPTH + 1)
) (
    input  wire logic               clk,
    input  wire logic               resetn,
    input  wire logic               push,
    input  wire logic [WIDTH-1:0]   push_data,
    input  wire logic               pop,
    output logic                    full,
    output logic                    empty,
    output logic [CNT_W-1:0]        count,
    output logic                    head_valid,
    output logic [DELAY_W-1:0]      head_delay,
    output logic [WIDTH-1:0]        head_data
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0]   r_data  [DEPTH];
    logic [DELAY_W-1:0] r_delay [DEPTH];
    logic [DEPTH-1:0]   r_valid;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic [DEPTH-1:0]   w_valid_next;
    logic               w_push;
    logic               w_pop;

    // Explicit wrap keeps non-power-of-two depths in range.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_push = push & ~full;
    assign w_pop  = pop & ~empty;

    always_comb begin
        w_valid_next = r_valid;
        if (w_pop) begin
            w_valid_next[r_rd_ptr] = 1'b0;
        end
        if (w_push) begin
            w_valid_next[r_wr_ptr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_valid  <= '0;
        end else begin
            r_valid <= w_valid_next;
            if (w_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_data[r_wr_ptr] <= push_data;
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        always_ff @(posedge clk) begin
            if (!resetn) begin
                r_delay[i] <= '0;
            end else if (w_push && (r_wr_ptr == PTR_W'(i))) begin
                r_delay[i] <= DELAY_W'(DELAY_INIT);
            end else if (r_valid[i] && (r_delay[i] != '0)) begin
                r_delay[i] <= r_delay[i] - 1'b1;
            end
        end
    end

    assign full       = (r_count == CNT_W'(DEPTH));
    assign empty      = (r_count == '0);
    assign count      = r_count;
    assign head_valid = r_valid[r_rd_ptr];
    assign head_delay = r_delay[r_rd_ptr];
    assign head_data  = r_data[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/data_sram_responder.sv
`default_nettype none
// ============================================================================
// Module      : data_sram_responder
// Description : Word-addressed data SRAM model with bounded, delayed responses.
// Revision    : 1.0 - initial release
// ============================================================================
module data_sram_responder
    import data_sram_responder_pkg::*;
#(
    parameter int ADDR_WIDTH  = 10,
    parameter int OUTSTANDING = 2,
    parameter int RESP_DELAY  = 1
) (
    input  wire logic             clk,
    input  wire logic             resetn,
    input  wire logic             hold,
    data_sram_responder_if.slave  bus
);
    localparam int DEPTH_WORDS = 1 << ADDR_WIDTH;
    localparam int ENTRY_W     = 33;
    localparam int CNT_W       = $clog2(OUTSTANDING + 1);

    logic [31:0]           r_mem [DEPTH_WORDS];
    logic [ADDR_WIDTH-1:0] w_idx;
    logic [31:0]           w_rd_word;
    logic                  w_addr_ok;
    logic                  w_accept;
    logic                  w_data_ok;
    logic [ENTRY_W-1:0]    w_push_data;
    logic [ENTRY_W-1:0]    w_head_data;
    logic [DELAY_W-1:0]    w_head_delay;
    logic                  w_head_valid;
    logic [CNT_W-1:0]      w_count;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_unused;

    assign w_idx     = bus.addr[ADDR_WIDTH+1:2];
    assign w_rd_word = r_mem[w_idx];

    // Count is taken before any same-cycle pop, so a full queue never accepts.
    assign w_addr_ok = resetn & ~hold & (w_count < CNT_W'(OUTSTANDING));
    assign w_accept  = bus.req & w_addr_ok;

    always_ff @(posedge clk) begin
        if (w_accept && bus.wr) begin
            r_mem[w_idx] <= merge_lanes(r_mem[w_idx], bus.wdata, bus.wstrb);
        end
    end

    // Loads capture the word now, so they observe every earlier accepted store.
    assign w_push_data = {~bus.wr, bus.wr ? 32'd0 : w_rd_word};

    resp_fifo #(
        .DEPTH      (OUTSTANDING),
        .WIDTH      (ENTRY_W),
        .DELAY_W    (DELAY_W),
        .DELAY_INIT (RESP_DELAY),
        .CNT_W      (CNT_W)
    ) u_resp_fifo (
        .clk        (clk),
        .resetn     (resetn),
        .push       (w_accept),
        .push_data  (w_push_data),
        .pop        (w_data_ok),
        .full       (w_full),
        .empty      (w_empty),
        .count      (w_count),
        .head_valid (w_head_valid),
        .head_delay (w_head_delay),
        .head_data  (w_head_data)
    );

    assign w_data_ok   = resetn & w_head_valid & (w_head_delay == '0);
    assign bus.addr_ok = w_addr_ok;
    assign bus.data_ok = w_data_ok;
    assign bus.rdata   = (w_data_ok & w_head_data[32]) ? w_head_data[31:0] : 32'd0;

    assign w_unused = ^{bus.addr[31:ADDR_WIDTH+2], bus.addr[1:0], bus.size, w_full, w_empty};

endmodule
`default_nettype wire

// File: tb/tb_data_sram_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_sram_responder
// Description : Scoreboard bench for two responder configurations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_sram_responder;
    import data_sram_responder_pkg::*;

    localparam int AW = 10;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    logic hold_a = 1'b0;
    logic hold_b = 1'b0;

    data_sram_responder_if bus_a ();
    data_sram_responder_if bus_b ();

    data_sram_responder #(.ADDR_WIDTH(AW), .OUTSTANDING(2), .RESP_DELAY(1)) dut_a (
        .clk(clk), .resetn(resetn), .hold(hold_a), .bus(bus_a)
    );
    data_sram_responder #(.ADDR_WIDTH(AW), .OUTSTANDING(2), .RESP_DELAY(3)) dut_b (
        .clk(clk), .resetn(resetn), .hold(hold_b), .bus(bus_b)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] model_a [int];
    logic [31:0] model_b [int];
    logic [31:0] exp_a [$];
    logic [31:0] exp_b [$];
    int          resp_cyc_a [$];
    int          resp_cyc_b [$];
    logic [31:0] rdata_hist_b [$];
    logic [31:0] last_rdata_a;
    logic [31:0] e_a, e_b;

    always @(negedge clk) begin
        if (bus_a.data_ok === 1'b1) begin
            checks++;
            resp_cyc_a.push_back(cyc);
            last_rdata_a = bus_a.rdata;
            if (exp_a.size() == 0) begin
                errors++;
                $display("FAIL a_unexpected_data_ok: got data_ok=1 rdata=%h, required no response", bus_a.rdata);
            end else begin
                e_a = exp_a.pop_front();
                if (bus_a.rdata !== e_a) begin
                    errors++;
                    $display("FAIL a_rdata: got %h, required %h", bus_a.rdata, e_a);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (bus_b.data_ok === 1'b1) begin
            checks++;
            resp_cyc_b.push_back(cyc);
            rdata_hist_b.push_back(bus_b.rdata);
            if (exp_b.size() == 0) begin
                errors++;
                $display("FAIL b_unexpected_data_ok: got data_ok=1 rdata=%h, required no response", bus_b.rdata);
            end else begin
                e_b = exp_b.pop_front();
                if (bus_b.rdata !== e_b) begin
                    errors++;
                    $display("FAIL b_rdata: got %h, required %h", bus_b.rdata, e_b);
                end
            end
        end
    end

    // Drives one request until accepted; records expected response at accept.
    task automatic issue(input bit sel_b, input logic w, input logic [3:0] strb,
                         input logic [31:0] a, input logic [31:0] d, output int acc);
        int          n;
        bit          ok;
        int          idx;
        logic [31:0] word;
        idx = int'(a[AW+1:2]);
        acc = -1;
        if (sel_b) begin
            bus_b.req = 1'b1; bus_b.wr = w; bus_b.wstrb = strb;
            bus_b.addr = a; bus_b.wdata = d; bus_b.size = SIZE_WORD;
        end else begin
            bus_a.req = 1'b1; bus_a.wr = w; bus_a.wstrb = strb;
            bus_a.addr = a; bus_a.wdata = d; bus_a.size = SIZE_WORD;
        end
        n  = 0;
        ok = 1'b0;
        while (!ok && n < 40) begin
            @(negedge clk);
            ok = sel_b ? (bus_b.addr_ok === 1'b1) : (bus_a.addr_ok === 1'b1);
            n++;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: addr=%h addr_ok stayed 0, required 1 within 40 cycles", a);
        end else begin
            acc = cyc;
            if (sel_b) word = model_b.exists(idx) ? model_b[idx] : 32'd0;
            else       word = model_a.exists(idx) ? model_a[idx] : 32'd0;
            if (w) begin
                for (int i = 0; i < 4; i++) begin
                    if (strb[i]) word[8*i +: 8] = d[8*i +: 8];
                end
                if (sel_b) begin model_b[idx] = word; exp_b.push_back(32'd0); end
                else       begin model_a[idx] = word; exp_a.push_back(32'd0); end
            end else begin
                if (sel_b) exp_b.push_back(word);
                else       exp_a.push_back(word);
            end
        end
        @(posedge clk);
        #1;
        if (sel_b) bus_b.req = 1'b0;
        else       bus_a.req = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_a.size() != 0 || exp_b.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_a.size() != 0 || exp_b.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: pending a=%0d b=%0d, required 0", exp_a.size(), exp_b.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus_a.req = 1'b1; bus_a.wr = 1'b0; bus_a.addr = 32'h100;
        repeat (3) @(negedge clk);
        checks += 4;
        if (bus_a.addr_ok !== 1'b0) begin errors++; $display("FAIL reset_addr_ok: got %b, required 0", bus_a.addr_ok); end
        if (bus_a.data_ok !== 1'b0) begin errors++; $display("FAIL reset_data_ok: got %b, required 0", bus_a.data_ok); end
        if (bus_a.rdata !== 32'd0)  begin errors++; $display("FAIL reset_rdata: got %h, required 0", bus_a.rdata); end
        if (bus_b.addr_ok !== 1'b0) begin errors++; $display("FAIL reset_addr_ok_b: got %b, required 0", bus_b.addr_ok); end
        @(posedge clk);
        #1;
        bus_a.req = 1'b0;
        resetn    = 1'b1;
        @(negedge clk);
        checks++;
        if (bus_a.addr_ok !== 1'b1) begin errors++; $display("FAIL post_reset_addr_ok: got %b, required 1", bus_a.addr_ok); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_store_load();
        int s, l;
        resp_cyc_a.delete();
        issue(1'b0, 1'b1, 4'hF, 32'h100, 32'hDEADBEEF, s);
        issue(1'b0, 1'b0, 4'hF, 32'h100, 32'h0, l);
        drain();
        checks += 4;
        if (resp_cyc_a.size() != 2) begin errors++; $display("FAIL sl_resp_count: got %0d, required 2", resp_cyc_a.size()); end
        if (last_rdata_a !== 32'hDEADBEEF) begin errors++; $display("FAIL sl_rdata: got %h, required deadbeef", last_rdata_a); end
        if (resp_cyc_a.size() > 0 && resp_cyc_a[0] != s + 2) begin
            errors++; $display("FAIL sl_store_latency: got %0d, required %0d", resp_cyc_a[0] - s, 2);
        end
        if (resp_cyc_a.size() > 1 && resp_cyc_a[1] != l + 2) begin
            errors++; $display("FAIL sl_load_latency: got %0d, required %0d", resp_cyc_a[1] - l, 2);
        end
    endtask

    task automatic test_byte_lane();
        int t;
        issue(1'b0, 1'b1, 4'hF, 32'h200, 32'h11223344, t);
        issue(1'b0, 1'b1, 4'b0100, 32'h202, 32'hAAAAAAAA, t);
        issue(1'b0, 1'b0, 4'hF, 32'h202, 32'h0, t);
        drain();
        checks++;
        if (last_rdata_a !== 32'h11AA3344) begin errors++; $display("FAIL byte_lane: got %h, required 11aa3344", last_rdata_a); end
        resp_cyc_a.delete();
        issue(1'b0, 1'b1, 4'b0000, 32'h200, 32'hFFFFFFFF, t);
        issue(1'b0, 1'b0, 4'hF, 32'h200, 32'h0, t);
        drain();
        checks += 2;
        if (resp_cyc_a.size() != 2) begin errors++; $display("FAIL zero_strb_resp: got %0d, required 2", resp_cyc_a.size()); end
        if (last_rdata_a !== 32'h11AA3344) begin errors++; $display("FAIL zero_strb_data: got %h, required 11aa3344", last_rdata_a); end
    endtask

    task automatic test_alias();
        int t;
        issue(1'b0, 1'b1, 4'hF, 32'h100, 32'h5, t);
        issue(1'b0, 1'b0, 4'hF, 32'h100 + (32'd1 << (AW + 2)), 32'h0, t);
        drain();
        checks++;
        if (last_rdata_a !== 32'h5) begin errors++; $display("FAIL alias: got %h, required 00000005", last_rdata_a); end
        issue(1'b0, 1'b0, 4'hF, 32'h103, 32'h0, t);
        drain();
        checks++;
        if (last_rdata_a !== 32'h5) begin errors++; $display("FAIL low_bits_ignored: got %h, required 00000005", last_rdata_a); end
    endtask

    task automatic test_hold();
        int c0, acc;
        hold_a = 1'b1;
        bus_a.req = 1'b1; bus_a.wr = 1'b0; bus_a.addr = 32'h100;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (bus_a.addr_ok !== 1'b0 || bus_a.data_ok !== 1'b0) begin
                errors++;
                $display("FAIL hold_cycle%0d: got addr_ok=%b data_ok=%b, required 0 0", i, bus_a.addr_ok, bus_a.data_ok);
            end
        end
        @(posedge clk);
        #1;
        hold_a = 1'b0;
        c0 = cyc;
        issue(1'b0, 1'b0, 4'hF, 32'h100, 32'h0, acc);
        checks++;
        if (acc != c0) begin errors++; $display("FAIL hold_release_accept: got cycle %0d, required %0d", acc, c0); end
        drain();
    endtask

    task automatic test_reset_pending();
        int n_ok, t;
        bus_a.req = 1'b1; bus_a.wr = 1'b0; bus_a.addr = 32'h200;
        @(negedge clk);
        checks++;
        if (bus_a.addr_ok !== 1'b1) begin errors++; $display("FAIL rp_accept1: got %b, required 1", bus_a.addr_ok); end
        @(posedge clk);
        #1;
        bus_a.addr = 32'h100;
        @(negedge clk);
        checks++;
        if (bus_a.addr_ok !== 1'b1) begin errors++; $display("FAIL rp_accept2: got %b, required 1", bus_a.addr_ok); end
        @(posedge clk);
        #1;
        bus_a.req = 1'b0;
        resetn    = 1'b0;
        @(negedge clk);
        checks++;
        if (bus_a.data_ok !== 1'b0) begin errors++; $display("FAIL rp_in_reset_data_ok: got %b, required 0", bus_a.data_ok); end
        @(posedge clk);
        #1;
        resetn = 1'b1;
        n_ok = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus_a.data_ok === 1'b1) n_ok++;
        end
        checks += 2;
        if (n_ok != 0) begin errors++; $display("FAIL rp_discard: got %0d responses, required 0", n_ok); end
        if (bus_a.addr_ok !== 1'b1) begin errors++; $display("FAIL rp_queue_empty: got addr_ok=%b, required 1", bus_a.addr_ok); end
        @(posedge clk);
        #1;
        issue(1'b0, 1'b0, 4'hF, 32'h200, 32'h0, t);
        drain();
        checks++;
        if (last_rdata_a !== 32'h11AA3344) begin errors++; $display("FAIL rp_mem_persist: got %h, required 11aa3344", last_rdata_a); end
    endtask

    task automatic test_back_to_back();
        int t, a1, a2, a3;
        issue(1'b1, 1'b1, 4'hF, 32'h10, 32'h000000A1, t);
        issue(1'b1, 1'b1, 4'hF, 32'h14, 32'h000000B2, t);
        issue(1'b1, 1'b1, 4'hF, 32'h18, 32'h000000C3, t);
        drain();
        resp_cyc_b.delete();
        rdata_hist_b.delete();
        issue(1'b1, 1'b0, 4'hF, 32'h10, 32'h0, a1);
        issue(1'b1, 1'b0, 4'hF, 32'h14, 32'h0, a2);
        issue(1'b1, 1'b0, 4'hF, 32'h18, 32'h0, a3);
        drain();
        checks += 5;
        if (a2 != a1 + 1) begin errors++; $display("FAIL b2b_second_accept: got +%0d, required +1", a2 - a1); end
        if (a3 != a1 + 5) begin errors++; $display("FAIL b2b_third_accept: got +%0d, required +5", a3 - a1); end
        if (resp_cyc_b.size() != 3) begin
            errors++; $display("FAIL b2b_resp_count: got %0d, required 3", resp_cyc_b.size());
        end else begin
            if (resp_cyc_b[0] != a1 + 4) begin errors++; $display("FAIL b2b_first_resp: got +%0d, required +4", resp_cyc_b[0] - a1); end
            if (rdata_hist_b[0] !== 32'hA1 || rdata_hist_b[1] !== 32'hB2 || rdata_hist_b[2] !== 32'hC3) begin
                errors++;
                $display("FAIL b2b_order: got %h %h %h, required a1 b2 c3", rdata_hist_b[0], rdata_hist_b[1], rdata_hist_b[2]);
            end
        end
    endtask

    initial begin
        bus_a.req = 1'b0; bus_a.wr = 1'b0; bus_a.size = SIZE_WORD;
        bus_a.wstrb = 4'h0; bus_a.addr = 32'h0; bus_a.wdata = 32'h0;
        bus_b.req = 1'b0; bus_b.wr = 1'b0; bus_b.size = SIZE_WORD;
        bus_b.wstrb = 4'h0; bus_b.addr = 32'h0; bus_b.wdata = 32'h0;
        test_reset();
        test_store_load();
        test_byte_lane();
        test_alias();
        test_hold();
        test_reset_pending();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit, required completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
